// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI bit counter.
// The optional completed-frame counter is enabled with SPI_BITCNT_FRAME_CNT_EN.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } bitcnt_state_t;

    // A frame length of 0, or one longer than the datapath supports, means
    // "use the full datapath width".
    function automatic int clamp_len(input int len, input int max_bits);
        return ((len == 0) || (len > max_bits)) ? max_bits : len;
    endfunction

endpackage

// File: rtl/spi_frame_counter.sv
// Wrapping counter of completed SPI frames. Only instantiated by
// spi_bit_counter when SPI_BITCNT_FRAME_CNT_EN is defined.
module spi_frame_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count one per increment request and wrap naturally at 2^W.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/spi_bit_counter.sv
// SPI frame bit counter: counts shifted bits against a per-frame length,
// reports busy / last_bit, pulses done for one cycle at frame end, and
// supports abort and back-to-back frames (start during DONE).
// Define SPI_BITCNT_FRAME_CNT_EN to add the frame_count output.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int MAX_BITS    = 32,
    parameter int CW          = $clog2(MAX_BITS + 1),
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   BaudRate,
    input  logic                   rst,
    input  logic                   counter_enable_master,
    input  logic                   counter_enable_slave,
    input  logic                   start,
    input  logic [CW-1:0]          frame_len,
    input  logic                   abort,
    output logic [CW-1:0]          counter,
    output logic                   busy,
    output logic                   last_bit,
    output logic                   done
`ifdef SPI_BITCNT_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

    // Reject configurations the counter cannot represent.
    if (MAX_BITS < 2 || FRAME_CNT_W < 1) begin : g_bad_cfg
        $error("spi_bit_counter: MAX_BITS must be >= 2 and FRAME_CNT_W >= 1");
    end

    bitcnt_state_t state, state_nxt;
    logic [CW-1:0] len, len_nxt;
    logic [CW-1:0] counter_nxt;
    logic [CW-1:0] len_clamped;
    logic [CW-1:0] len_m1;
    logic          adv;

    // Both paths may request the same bit; treat it as a single advance.
    assign adv         = counter_enable_master | counter_enable_slave;
    assign len_clamped = CW'(clamp_len(32'(frame_len), MAX_BITS));
    assign len_m1      = len - CW'(1);

    // State, frame length and bit count registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge BaudRate) begin
        if (rst) begin
            state   <= IDLE;
            len     <= CW'(MAX_BITS);
            counter <= '0;
        end else begin
            state   <= state_nxt;
            len     <= len_nxt;
            counter <= counter_nxt;
        end
    end

    // Next-state, length latch and counter update.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        counter_nxt = counter;
        unique case (state)
            IDLE: begin
                counter_nxt = '0;
                if (start) begin
                    state_nxt = COUNT;
                    len_nxt   = len_clamped;
                end
            end
            COUNT: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                end else if (adv) begin
                    counter_nxt = counter + CW'(1);
                    if (counter == len_m1) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                counter_nxt = '0;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = COUNT;
                    len_nxt   = len_clamped;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                counter_nxt = '0;
            end
        endcase
    end

    // Status decodes from registered state, so last_bit is valid while the
    // final advance is being presented.
    always_comb begin
        busy     = (state == COUNT);
        done     = (state == DONE);
        last_bit = (state == COUNT) && (counter == len_m1);
    end

`ifdef SPI_BITCNT_FRAME_CNT_EN
    spi_frame_counter #(
        .W(FRAME_CNT_W)
    ) u_frame_counter (
        .clk  (BaudRate),
        .rst  (rst),
        .inc  (done),
        .count(frame_count)
    );
`endif

endmodule

// File: tb/tb_spi_bit_counter.sv
// Self-checking bench for spi_bit_counter: a frame-level reference model is
// compared against the DUT every cycle, plus directed literal checks.
// Define SPI_BITCNT_FRAME_CNT_EN to also exercise frame_count.
module tb_spi_bit_counter;

    localparam int MAX_BITS = 32;
    localparam int CW       = $clog2(MAX_BITS + 1);
    localparam int FCW      = 2;

    logic          BaudRate;
    logic          rst;
    logic          counter_enable_master;
    logic          counter_enable_slave;
    logic          start;
    logic [CW-1:0] frame_len;
    logic          abort;
    logic [CW-1:0] counter;
    logic          busy;
    logic          last_bit;
    logic          done;
`ifdef SPI_BITCNT_FRAME_CNT_EN
    logic [FCW-1:0] frame_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    spi_bit_counter #(
        .MAX_BITS   (MAX_BITS),
        .FRAME_CNT_W(FCW)
    ) dut (
        .BaudRate             (BaudRate),
        .rst                  (rst),
        .counter_enable_master(counter_enable_master),
        .counter_enable_slave (counter_enable_slave),
        .start                (start),
        .frame_len            (frame_len),
        .abort                (abort),
        .counter              (counter),
        .busy                 (busy),
        .last_bit             (last_bit),
        .done                 (done)
`ifdef SPI_BITCNT_FRAME_CNT_EN
        ,
        .frame_count          (frame_count)
`endif
    );

    initial BaudRate = 1'b0;
    always #5 BaudRate = ~BaudRate;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level) ----------------
    bit m_valid  = 0;
    bit m_active = 0;   // a frame is being counted
    bit m_done   = 0;   // this cycle is the done pulse
    int m_bits   = 0;   // bits completed in the visible frame
    int m_len    = MAX_BITS;
    int m_fc     = 0;

    function automatic int eff_len(input int fl);
        return (fl == 0 || fl > MAX_BITS) ? MAX_BITS : fl;
    endfunction

    always @(posedge BaudRate) begin
        if (rst) begin
            m_valid  = 1;
            m_active = 0;
            m_done   = 0;
            m_bits   = 0;
            m_len    = MAX_BITS;
            m_fc     = 0;
        end else if (m_valid) begin
            if (m_done) begin
                m_fc   = (m_fc + 1) % (1 << FCW);
                m_done = 0;
                m_bits = 0;
                if (!abort && start) begin
                    m_active = 1;
                    m_len    = eff_len(int'(frame_len));
                end
            end else if (m_active) begin
                if (abort) begin
                    m_active = 0;
                    m_bits   = 0;
                end else if (counter_enable_master || counter_enable_slave) begin
                    m_bits++;
                    if (m_bits == m_len) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end else if (start) begin
                m_active = 1;
                m_bits   = 0;
                m_len    = eff_len(int'(frame_len));
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge BaudRate) begin
        if (m_valid) begin
            check("counter", 64'(counter), 64'(m_bits));
            check("busy", 64'(busy), 64'(m_active));
            check("last_bit", 64'(last_bit), 64'(m_active && (m_bits == m_len - 1)));
            check("done", 64'(done), 64'(m_done));
`ifdef SPI_BITCNT_FRAME_CNT_EN
            check("frame_count", 64'(frame_count), 64'(m_fc));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change just after a falling edge; the task returns at the next
    // falling edge so outputs reflect the rising edge that sampled them.
    task automatic drive(input bit r, input bit am, input bit as_, input bit st,
                         input int fl, input bit ab);
        rst                   = r;
        counter_enable_master = am;
        counter_enable_slave  = as_;
        start                 = st;
        frame_len             = CW'(fl);
        abort                 = ab;
        @(negedge BaudRate);
    endtask

    task automatic idle_cyc();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic adv_cyc(input bit ab);
        int k;
        k = $urandom_range(1, 3);
        drive(0, k[0], k[1], 0, 0, ab);
    endtask

    // n advances with random gaps; gap cycles carry ignored start noise.
    task automatic send_bits(input int n, input bit pin_last);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) drive(0, 0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 63), 0);
            if (pin_last && i == n - 1) check("last_bit_before_final", 64'(last_bit), 64'd1);
            adv_cyc(0);
        end
    endtask

    task automatic adv_until_done(input string name, input int exp_bits);
        int cnt;
        cnt = 0;
        while (!done && cnt <= 100) begin
            adv_cyc(0);
            cnt++;
        end
        check(name, 64'(cnt), 64'(exp_bits));
    endtask

    initial begin
        // 1. reset, then idle with adv toggling
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("reset_counter", 64'(counter), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        for (int i = 0; i < 12; i++) drive(0, 1'(i % 2), 1'(i % 3 == 0), 0, 0, 0);
        check("idle_counter", 64'(counter), 64'd0);

        // 2. len 8 with random gaps
        drive(0, 0, 0, 1, 8, 0);
        check("start_busy", 64'(busy), 64'd1);
        send_bits(7, 0);
        check("counter_at_7", 64'(counter), 64'd7);
        send_bits(1, 1);
        check("done_len8", 64'(done), 64'd1);
        check("done_counter8", 64'(counter), 64'd8);
        check("done_busy_low", 64'(busy), 64'd0);
        idle_cyc();
        check("after_done_counter", 64'(counter), 64'd0);
        check("after_done_pulse", 64'(done), 64'd0);

        // 3. clamped lengths
        drive(0, 0, 0, 1, 0, 0);
        adv_until_done("adv_to_done_len0", 32);
        idle_cyc();
        drive(0, 0, 0, 1, 40, 0);
        adv_until_done("adv_to_done_len40", 32);
        check("done_counter32", 64'(counter), 64'd32);
        idle_cyc();

        // 4. aborts
        drive(0, 0, 0, 1, 8, 0);
        send_bits(3, 0);
        drive(0, 0, 0, 1, 5, 1);  // abort beats start
        check("abort3_busy", 64'(busy), 64'd0);
        check("abort3_counter", 64'(counter), 64'd0);
        repeat (3) idle_cyc();
        drive(0, 0, 0, 1, 8, 0);
        send_bits(7, 0);
        adv_cyc(1);               // abort beats the final advance
        check("abort_final_done", 64'(done), 64'd0);
        check("abort_final_counter", 64'(counter), 64'd0);
        idle_cyc();
        check("abort_final_no_done", 64'(done), 64'd0);
        drive(0, 0, 0, 1, 2, 0);
        send_bits(2, 0);
        check("done_before_abort", 64'(done), 64'd1);
        drive(0, 0, 0, 1, 3, 1);  // abort in DONE
        check("abort_in_done_busy", 64'(busy), 64'd0);
        check("abort_in_done_done", 64'(done), 64'd0);

        // 5. back-to-back: start in DONE
        drive(0, 0, 0, 1, 4, 0);
        send_bits(4, 1);
        check("b2b_first_done", 64'(done), 64'd1);
        drive(0, 0, 0, 1, 2, 0);
        check("b2b_no_gap_busy", 64'(busy), 64'd1);
        check("b2b_counter0", 64'(counter), 64'd0);
        adv_cyc(0);
        adv_cyc(0);
        check("b2b_second_done", 64'(done), 64'd1);
        check("b2b_second_counter", 64'(counter), 64'd2);
        idle_cyc();

        // reset mid-frame and during DONE
        drive(0, 0, 0, 1, 6, 0);
        send_bits(2, 0);
        drive(1, 1, 0, 0, 0, 0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_counter", 64'(counter), 64'd0);
        drive(0, 0, 0, 1, 1, 0);
        adv_cyc(0);
        check("len1_done", 64'(done), 64'd1);
        drive(1, 0, 0, 1, 3, 0);
        check("rst_in_done", 64'(done), 64'd0);
        check("rst_in_done_busy", 64'(busy), 64'd0);

`ifdef SPI_BITCNT_FRAME_CNT_EN
        // 6. five frames plus one aborted -> wraps to 1 with a 2-bit counter
        for (int f = 0; f < 5; f++) begin
            drive(0, 0, 0, 1, $urandom_range(1, 4), 0);
            while (!done) adv_cyc(0);
            idle_cyc();
        end
        drive(0, 0, 0, 1, 3, 0);
        adv_cyc(0);
        drive(0, 0, 0, 0, 0, 1);
        idle_cyc();
        check("frame_count_wrap", 64'(frame_count), 64'd1);
        drive(1, 0, 0, 0, 0, 0);
        check("frame_count_rst", 64'(frame_count), 64'd0);
`endif

        // 7. random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int fl;
            fl = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 9);
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 3), fl,
                  ($urandom_range(0, 49) == 0));
        end

        idle_cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
